// File: rtl/ps2_keycode_fifo_module.sv
// PS/2 make-code FIFO: folds the E0 extended prefix into bit 8 of each entry, show-ahead read.
// Optional PS2_ASCII_EN macro adds the oAscii head-entry lookup output.
module ps2_keycode_fifo_module #(
  parameter int DEPTH_LOG2 = 3,
  parameter logic [7:0] EXT_PREFIX = 8'hE0
) (
  input  logic                  CLOCK,
  input  logic                  RST_n,
  input  logic                  iTrig,
  input  logic [7:0]            iData,
  input  logic                  iRead,
  input  logic                  iClrOvf,
  output logic [8:0]            oCode,
  output logic                  oEmpty,
  output logic                  oFull,
  output logic [DEPTH_LOG2:0]   oCount,
`ifdef PS2_ASCII_EN
  output logic [7:0]            oAscii,
`endif
  output logic                  oOverflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   CNT_ZERO = {(DEPTH_LOG2 + 1){1'b0}};
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = {DEPTH_LOG2{1'b0}};

  typedef enum logic {IDLE = 1'b0, EXT = 1'b1} state_t;

  state_t                state_r;
  logic [8:0]            mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wrPtr_r, rdPtr_r, rdPtrNext_s;
  logic [DEPTH_LOG2:0]   count_r, countNext_s;
  logic [8:0]            headCode_r, headNext_s, wrData_s;
  logic                  empty_r, full_r, overflow_r;
  logic                  wrReq_s, wrAccept_s, rdAccept_s, drop_s;

  // Decode the incoming byte into a write request and the entry it would store.
  always_comb begin
    wrReq_s    = 1'b0;
    wrData_s   = {(state_r == EXT), iData};
    if (iTrig && (iData != EXT_PREFIX)) begin
      wrReq_s = 1'b1;
    end else begin
      wrReq_s = 1'b0;
    end
    rdAccept_s = iRead && !empty_r;
    // A full FIFO still takes a write when the same cycle frees a slot.
    wrAccept_s = wrReq_s && (!full_r || rdAccept_s);
    drop_s     = wrReq_s && full_r && !rdAccept_s;
  end

  // Next occupancy, read pointer and head entry for the show-ahead output register.
  always_comb begin
    countNext_s = count_r;
    case ({wrAccept_s, rdAccept_s})
      2'b10:   countNext_s = count_r + CNT_ONE;
      2'b01:   countNext_s = count_r - CNT_ONE;
      default: countNext_s = count_r;
    endcase
    if (rdAccept_s) begin
      rdPtrNext_s = rdPtr_r + PTR_ONE;
    end else begin
      rdPtrNext_s = rdPtr_r;
    end
    // The entry being written bypasses storage when it becomes the new head.
    if (countNext_s == CNT_ZERO) begin
      headNext_s = 9'h000;
    end else if (wrAccept_s && ((count_r == CNT_ZERO) || ((count_r == CNT_ONE) && rdAccept_s))) begin
      headNext_s = wrData_s;
    end else begin
      headNext_s = mem_r[rdPtrNext_s];
    end
  end

  // Prefix FSM: remembers a pending E0 until the next non-prefix byte.
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      state_r <= IDLE;
    end else begin
      case (state_r)
        IDLE: if (iTrig && (iData == EXT_PREFIX)) state_r <= EXT;
        EXT:  if (iTrig && (iData != EXT_PREFIX)) state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  // Entry storage; contents are don't-care after reset.
  always_ff @(posedge CLOCK) begin
    if (wrAccept_s) begin
      mem_r[wrPtr_r] <= wrData_s;
    end
  end

  // Pointers, occupancy, flags and registered head entry.
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      wrPtr_r    <= PTR_ZERO;
      rdPtr_r    <= PTR_ZERO;
      count_r    <= CNT_ZERO;
      empty_r    <= 1'b1;
      full_r     <= 1'b0;
      headCode_r <= 9'h000;
      overflow_r <= 1'b0;
    end else begin
      if (wrAccept_s) begin
        wrPtr_r <= wrPtr_r + PTR_ONE;
      end
      rdPtr_r    <= rdPtrNext_s;
      count_r    <= countNext_s;
      empty_r    <= (countNext_s == CNT_ZERO);
      full_r     <= (countNext_s == CNT_FULL);
      headCode_r <= headNext_s;
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (iClrOvf) begin
        overflow_r <= 1'b0;
      end
    end
  end

  assign oCode     = headCode_r;
  assign oEmpty    = empty_r;
  assign oFull     = full_r;
  assign oCount    = count_r;
  assign oOverflow = overflow_r;

`ifdef PS2_ASCII_EN
  function automatic logic [7:0] scanToAscii(input logic [7:0] code);
    case (code)
      8'h1C: scanToAscii = 8'h61; 8'h32: scanToAscii = 8'h62; 8'h21: scanToAscii = 8'h63;
      8'h23: scanToAscii = 8'h64; 8'h24: scanToAscii = 8'h65; 8'h2B: scanToAscii = 8'h66;
      8'h34: scanToAscii = 8'h67; 8'h33: scanToAscii = 8'h68; 8'h43: scanToAscii = 8'h69;
      8'h3B: scanToAscii = 8'h6A; 8'h42: scanToAscii = 8'h6B; 8'h4B: scanToAscii = 8'h6C;
      8'h3A: scanToAscii = 8'h6D; 8'h31: scanToAscii = 8'h6E; 8'h44: scanToAscii = 8'h6F;
      8'h4D: scanToAscii = 8'h70; 8'h15: scanToAscii = 8'h71; 8'h2D: scanToAscii = 8'h72;
      8'h1B: scanToAscii = 8'h73; 8'h2C: scanToAscii = 8'h74; 8'h3C: scanToAscii = 8'h75;
      8'h2A: scanToAscii = 8'h76; 8'h1D: scanToAscii = 8'h77; 8'h22: scanToAscii = 8'h78;
      8'h35: scanToAscii = 8'h79; 8'h1A: scanToAscii = 8'h7A;
      8'h45: scanToAscii = 8'h30; 8'h16: scanToAscii = 8'h31; 8'h1E: scanToAscii = 8'h32;
      8'h26: scanToAscii = 8'h33; 8'h25: scanToAscii = 8'h34; 8'h2E: scanToAscii = 8'h35;
      8'h36: scanToAscii = 8'h36; 8'h3D: scanToAscii = 8'h37; 8'h3E: scanToAscii = 8'h38;
      8'h46: scanToAscii = 8'h39;
      8'h29: scanToAscii = 8'h20; 8'h5A: scanToAscii = 8'h0D; 8'h66: scanToAscii = 8'h08;
      default: scanToAscii = 8'h00;
    endcase
  endfunction

  // ASCII view of the head entry; extended keys and an empty FIFO read as zero.
  always_comb begin
    if (empty_r || headCode_r[8]) begin
      oAscii = 8'h00;
    end else begin
      oAscii = scanToAscii(headCode_r[7:0]);
    end
  end
`endif

endmodule

// File: tb/tb_ps2_keycode_fifo_module.sv
// Directed bench for ps2_keycode_fifo_module; oAscii checks compile in with PS2_ASCII_EN.
module tb_ps2_keycode_fifo_module;

  logic       CLOCK = 1'b0;
  logic       RST_n = 1'b0;
  logic       iTrig = 1'b0;
  logic [7:0] iData = 8'h00;
  logic       iRead = 1'b0;
  logic       iClrOvf = 1'b0;
  logic [8:0] oCode;
  logic       oEmpty, oFull, oOverflow;
  logic [3:0] oCount;
`ifdef PS2_ASCII_EN
  logic [7:0] oAscii;
`endif
  int total = 0;
  int bad = 0;

  ps2_keycode_fifo_module dut (
    .CLOCK(CLOCK), .RST_n(RST_n), .iTrig(iTrig), .iData(iData), .iRead(iRead),
    .iClrOvf(iClrOvf), .oCode(oCode), .oEmpty(oEmpty), .oFull(oFull), .oCount(oCount),
`ifdef PS2_ASCII_EN
    .oAscii(oAscii),
`endif
    .oOverflow(oOverflow)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic trig, input logic [7:0] data, input logic rd, input logic clr);
    iTrig = trig; iData = data; iRead = rd; iClrOvf = clr;
    @(posedge CLOCK); #1;
    iTrig = 1'b0; iRead = 1'b0; iClrOvf = 1'b0;
  endtask

  task automatic wr(input logic [7:0] data);
    cyc(1'b1, data, 1'b0, 1'b0);
  endtask

  task automatic pop();
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic doReset();
    RST_n = 1'b0;
    @(posedge CLOCK); #1;
    chk("rst_count", 16'(oCount), 16'd0);
    chk("rst_empty", 16'(oEmpty), 16'd1);
    chk("rst_code", 16'(oCode), 16'h000);
    RST_n = 1'b1;
    @(posedge CLOCK); #1;
  endtask

  initial begin
    // reset state
    @(posedge CLOCK); @(posedge CLOCK); #1;
    chk("rst_count", 16'(oCount), 16'd0);
    chk("rst_empty", 16'(oEmpty), 16'd1);
    chk("rst_full", 16'(oFull), 16'd0);
    chk("rst_ovf", 16'(oOverflow), 16'd0);
    chk("rst_code", 16'(oCode), 16'h000);
    RST_n = 1'b1;
    @(posedge CLOCK); #1;

    // single write is visible the next cycle
    wr(8'h1C);
    chk("w1_code", 16'(oCode), 16'h01C);
    chk("w1_empty", 16'(oEmpty), 16'd0);
    chk("w1_count", 16'(oCount), 16'd1);
    pop();
    chk("p1_empty", 16'(oEmpty), 16'd1);
    chk("p1_count", 16'(oCount), 16'd0);

    // extended prefix folding
    wr(8'hE0);
    chk("pre_nowrite", 16'(oEmpty), 16'd1);
    wr(8'hE0);
    chk("pre2_nowrite", 16'(oCount), 16'd0);
    wr(8'h75);
    chk("ext_code", 16'(oCode), 16'h175);
    chk("ext_count", 16'(oCount), 16'd1);
    wr(8'h16);
    chk("ext2_count", 16'(oCount), 16'd2);
    chk("ext2_head", 16'(oCode), 16'h175);
    pop();
    chk("ext2_next", 16'(oCode), 16'h016);
    pop();
    chk("ext2_empty", 16'(oEmpty), 16'd1);

    // fill to full, then one dropped write
    for (int i = 1; i <= 8; i++) wr(8'(i));
    chk("fill_full", 16'(oFull), 16'd1);
    chk("fill_count", 16'(oCount), 16'd8);
    chk("fill_ovf", 16'(oOverflow), 16'd0);
    wr(8'h09);
    chk("drop_count", 16'(oCount), 16'd8);
    chk("drop_ovf", 16'(oOverflow), 16'd1);
    for (int i = 1; i <= 8; i++) begin
      chk("drop_order", 16'(oCode), 16'(i));
      pop();
    end
    chk("drain_empty", 16'(oEmpty), 16'd1);
    pop();
    chk("underflow", 16'(oCount), 16'd0);
    chk("ovf_sticky", 16'(oOverflow), 16'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr", 16'(oOverflow), 16'd0);

    // full with simultaneous read and write
    for (int i = 0; i < 8; i++) wr(8'(8'h11 + i));
    cyc(1'b1, 8'h20, 1'b1, 1'b0);
    chk("rw_full_count", 16'(oCount), 16'd8);
    chk("rw_full_ovf", 16'(oOverflow), 16'd0);
    chk("rw_full_head", 16'(oCode), 16'h012);
    for (int i = 0; i < 7; i++) begin
      chk("rw_full_order", 16'(oCode), 16'(8'h12 + i));
      pop();
    end
    chk("rw_full_last", 16'(oCode), 16'h020);
    pop();
    chk("rw_full_empty", 16'(oEmpty), 16'd1);

    // simultaneous read and write while empty and mid-level
    cyc(1'b1, 8'h33, 1'b1, 1'b0);
    chk("rw_empty_count", 16'(oCount), 16'd1);
    chk("rw_empty_code", 16'(oCode), 16'h033);
    wr(8'h34);
    cyc(1'b1, 8'h35, 1'b1, 1'b0);
    chk("rw_mid_count", 16'(oCount), 16'd2);
    chk("rw_mid_head", 16'(oCode), 16'h034);
    pop();
    chk("rw_mid_tail", 16'(oCode), 16'h035);
    pop();

    // overflow set wins over clear
    for (int i = 0; i < 8; i++) wr(8'(8'h41 + i));
    cyc(1'b1, 8'h49, 1'b0, 1'b1);
    chk("ovf_set_wins", 16'(oOverflow), 16'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr2", 16'(oOverflow), 16'd0);
    doReset();
    chk("flush_empty", 16'(oEmpty), 16'd1);

    // reset discards pending prefix
    wr(8'hE0);
    doReset();
    wr(8'h75);
    chk("rst_prefix", 16'(oCode), 16'h075);
    pop();

`ifdef PS2_ASCII_EN
    wr(8'h1C); wr(8'h45); wr(8'h5A); wr(8'hE0); wr(8'h6B);
    chk("asc_a", 16'(oAscii), 16'h61);
    pop();
    chk("asc_0", 16'(oAscii), 16'h30);
    pop();
    chk("asc_enter", 16'(oAscii), 16'h0D);
    pop();
    chk("asc_ext", 16'(oAscii), 16'h00);
    chk("asc_ext_code", 16'(oCode), 16'h16B);
    pop();
    chk("asc_empty", 16'(oAscii), 16'h00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
